// File: rtl/rfm_pkg.sv
// Shared definitions for the RFM activation-counter path: sequencer states and
// the counter/entry widths that cnt_cam and its controller must agree on.
package rfm_pkg;

    localparam int RFM_WORD_SIZE   = 16;
    localparam int RFM_ENTRY_WIDTH = 7;

    typedef enum logic [3:0] {
        INIT,
        IDLE,
        CLEAR,
        ACT_RD,
        ACT_WR,
        MAX,
        MAX_CAP,
        SEARCH,
        VCLR,
        DONE
    } state_t;

endpackage

// File: rtl/rfm_cnt_ctrl.sv
// Sequencer owning the cnt_cam port: activate-increment, RFM victim select/clear, table clear.
// Latency: increment ready again 3 cycles after accept; rfm_done 8 cycles after accept (7 without a victim).
// Backpressure: readies only in IDLE, priority clr_req > rfm > act, stalled never dropped; RFM_CNT_HALVE_EN decays the victim to max/2.
module rfm_cnt_ctrl
    import rfm_pkg::*;
#(
    parameter int                   WORD_SIZE   = RFM_WORD_SIZE,
    parameter int                   ENTRY_WIDTH = RFM_ENTRY_WIDTH,
    parameter logic [WORD_SIZE-1:0] ALERT_TH    = WORD_SIZE'(1024)
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   act_valid,
    input  logic [ENTRY_WIDTH-1:0] act_entry,
    output logic                   act_ready,
    input  logic                   rfm_valid,
    output logic                   rfm_ready,
    output logic                   rfm_done,
    output logic                   victim_found,
    output logic [ENTRY_WIDTH-1:0] victim_entry,
    output logic [WORD_SIZE-1:0]   victim_count,
    input  logic                   clr_req,
    output logic                   rfm_alert,
    output logic [WORD_SIZE-1:0]   cam_data_in,
    output logic [ENTRY_WIDTH-1:0] cam_addr_in,
    output logic                   cam_read_en,
    output logic                   cam_write_en,
    output logic                   cam_search_en,
    output logic                   cam_reset,
    output logic                   cam_max_en,
    input  logic [WORD_SIZE-1:0]   cam_data_out,
    input  logic [ENTRY_WIDTH-1:0] cam_addr_out,
    input  logic                   cam_match,
    input  logic [WORD_SIZE-1:0]   cam_max
);

    state_t                 state;
    logic [1:0]             scan;
    logic                   idle_q;
    logic [ENTRY_WIDTH-1:0] entry_q;
    logic [WORD_SIZE-1:0]   cnt_q;
    logic [WORD_SIZE-1:0]   max_q;
    logic [ENTRY_WIDTH-1:0] addr_q;
    logic                   match_q;

    logic [WORD_SIZE-1:0]   inc;
    logic [WORD_SIZE-1:0]   clr_val;
    logic                   hit;
    logic                   fin;
    logic                   fin_match;
    logic [ENTRY_WIDTH-1:0] fin_addr;

    assign rfm_ready = idle_q & ~clr_req;
    assign act_ready = idle_q & ~clr_req & ~rfm_valid;

    assign inc = (&cam_data_out) ? cam_data_out : cam_data_out + WORD_SIZE'(1);

`ifdef RFM_CNT_HALVE_EN
    assign clr_val = max_q >> 1;
`else
    assign clr_val = '0;
`endif

    // A zero maximum means an empty table: nothing to clear, nothing to report.
    assign hit       = (max_q != '0) && cam_match;
    assign fin       = (state == VCLR) || ((state == SEARCH) && !hit);
    assign fin_match = (state == VCLR) ? match_q : cam_match;
    assign fin_addr  = (state == VCLR) ? addr_q  : cam_addr_out;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= INIT;
            scan          <= '0;
            idle_q        <= 1'b0;
            entry_q       <= '0;
            cnt_q         <= '0;
            max_q         <= '0;
            addr_q        <= '0;
            match_q       <= 1'b0;
            rfm_done      <= 1'b0;
            victim_found  <= 1'b0;
            victim_entry  <= '0;
            victim_count  <= '0;
            rfm_alert     <= 1'b0;
            cam_data_in   <= '0;
            cam_addr_in   <= '0;
            cam_read_en   <= 1'b0;
            cam_write_en  <= 1'b0;
            cam_search_en <= 1'b0;
            cam_reset     <= 1'b0;
            cam_max_en    <= 1'b0;
        end else begin
            cam_read_en   <= 1'b0;
            cam_write_en  <= 1'b0;
            cam_search_en <= 1'b0;
            cam_reset     <= 1'b0;
            cam_max_en    <= 1'b0;
            cam_addr_in   <= '0;
            cam_data_in   <= '0;
            rfm_done      <= 1'b0;

            case (state)
                // CAM contents survive rstn; the single cam_reset cycle here is what zeroes them.
                INIT: begin
                    if (!cam_reset) begin
                        cam_reset <= 1'b1;
                    end else begin
                        state  <= IDLE;
                        idle_q <= 1'b1;
                    end
                end
                IDLE: begin
                    if (clr_req) begin
                        state     <= CLEAR;
                        cam_reset <= 1'b1;
                        rfm_alert <= 1'b0;
                        idle_q    <= 1'b0;
                    end else if (rfm_valid) begin
                        state      <= MAX;
                        scan       <= '0;
                        cam_max_en <= 1'b1;
                        idle_q     <= 1'b0;
                    end else if (act_valid) begin
                        state       <= ACT_RD;
                        entry_q     <= act_entry;
                        cam_read_en <= 1'b1;
                        cam_addr_in <= act_entry;
                        idle_q      <= 1'b0;
                    end
                end
                CLEAR: begin
                    state  <= IDLE;
                    idle_q <= 1'b1;
                end
                ACT_RD: begin
                    cnt_q        <= inc;
                    cam_write_en <= 1'b1;
                    cam_addr_in  <= entry_q;
                    cam_data_in  <= inc;
                    state        <= ACT_WR;
                end
                ACT_WR: begin
                    if (cnt_q >= ALERT_TH) rfm_alert <= 1'b1;
                    state  <= IDLE;
                    idle_q <= 1'b1;
                end
                MAX: begin
                    scan <= scan + 2'd1;
                    if (scan == 2'd3) state <= MAX_CAP;
                    else              cam_max_en <= 1'b1;
                end
                MAX_CAP: begin
                    max_q         <= cam_max;
                    cam_search_en <= 1'b1;
                    cam_data_in   <= cam_max;
                    state         <= SEARCH;
                end
                SEARCH: begin
                    addr_q  <= cam_addr_out;
                    match_q <= cam_match;
                    if (hit) begin
                        state        <= VCLR;
                        cam_write_en <= 1'b1;
                        cam_addr_in  <= cam_addr_out;
                        cam_data_in  <= clr_val;
                    end
                end
                VCLR: ;
                DONE: begin
                    state  <= IDLE;
                    idle_q <= 1'b1;
                end
                default: state <= INIT;
            endcase

            if (fin) begin
                state        <= DONE;
                rfm_done     <= 1'b1;
                victim_found <= (max_q != '0) && fin_match;
                victim_entry <= fin_addr;
                victim_count <= max_q;
                rfm_alert    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rfm_cnt_ctrl.sv
// Directed bench for rfm_cnt_ctrl with a behavioural cnt_cam model and a victim scoreboard.
module tb_rfm_cnt_ctrl;

    logic        clk;
    logic        rstn;
    logic        act_valid;
    logic [6:0]  act_entry;
    logic        act_ready;
    logic        rfm_valid;
    logic        rfm_ready;
    logic        rfm_done;
    logic        victim_found;
    logic [6:0]  victim_entry;
    logic [15:0] victim_count;
    logic        clr_req;
    logic        rfm_alert;
    logic [15:0] cam_data_in;
    logic [6:0]  cam_addr_in;
    logic        cam_read_en;
    logic        cam_write_en;
    logic        cam_search_en;
    logic        cam_reset;
    logic        cam_max_en;
    logic [15:0] cam_data_out;
    logic [6:0]  cam_addr_out;
    logic        cam_match;
    logic [15:0] cam_max;

    rfm_cnt_ctrl dut (
        .clk          (clk),
        .rstn         (rstn),
        .act_valid    (act_valid),
        .act_entry    (act_entry),
        .act_ready    (act_ready),
        .rfm_valid    (rfm_valid),
        .rfm_ready    (rfm_ready),
        .rfm_done     (rfm_done),
        .victim_found (victim_found),
        .victim_entry (victim_entry),
        .victim_count (victim_count),
        .clr_req      (clr_req),
        .rfm_alert    (rfm_alert),
        .cam_data_in  (cam_data_in),
        .cam_addr_in  (cam_addr_in),
        .cam_read_en  (cam_read_en),
        .cam_write_en (cam_write_en),
        .cam_search_en(cam_search_en),
        .cam_reset    (cam_reset),
        .cam_max_en   (cam_max_en),
        .cam_data_out (cam_data_out),
        .cam_addr_out (cam_addr_out),
        .cam_match    (cam_match),
        .cam_max      (cam_max)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural cnt_cam: contents ignore rstn, max valid after 4 max_en cycles, lowest index wins search.
    logic [15:0] mem [0:127];
    logic        seeded = 1'b0;
    logic [1:0]  mode   = 2'd0;
    logic [15:0] max_r  = 16'h0;
    logic [15:0] mtmp;
    logic        pre_en;
    logic [6:0]  pre_addr;
    logic [15:0] pre_val;

    always @(posedge clk) begin
        if (!seeded) begin
            for (int i = 0; i < 128; i++) mem[i] <= 16'hA5A5 ^ 16'(i);
            seeded <= 1'b1;
        end else if (cam_reset) begin
            for (int i = 0; i < 128; i++) mem[i] <= 16'h0;
        end else if (cam_write_en) begin
            mem[cam_addr_in] <= cam_data_in;
        end else if (pre_en) begin
            mem[pre_addr] <= pre_val;
        end
        if (cam_max_en) begin
            if (mode == 2'd3) begin
                mtmp = 16'h0;
                for (int i = 0; i < 128; i++) if (mem[i] > mtmp) mtmp = mem[i];
                max_r <= mtmp;
            end
            mode <= mode + 2'd1;
        end else begin
            mode <= 2'd0;
        end
    end

    assign cam_data_out = cam_read_en ? mem[cam_addr_in] : 16'h0;
    assign cam_max      = max_r;

    always_comb begin
        cam_match    = 1'b0;
        cam_addr_out = 7'd0;
        if (cam_search_en)
            for (int i = 127; i >= 0; i--)
                if (mem[i] == cam_data_in) begin
                    cam_match    = 1'b1;
                    cam_addr_out = i[6:0];
                end
    end

    typedef struct {
        logic        found;
        logic [6:0]  entry;
        logic [15:0] count;
        int          lat;
        int          acc;
        bit          chk_entry;
    } exp_t;

    exp_t sb[$];
    exp_t mx;
    int   wr_cnt   = 0;
    int   done_cnt = 0;
    int   bus_viol = 0;

    always @(negedge clk) begin
        if (rstn) begin
            if (cam_write_en) wr_cnt++;
            if (cam_addr_in != 7'd0 && !(cam_read_en || cam_write_en)) bus_viol++;
            if (cam_data_in != 16'd0 && !(cam_write_en || cam_search_en)) bus_viol++;
            if (rfm_done) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    chk("unexpected_done", rfm_done, 0);
                end else begin
                    mx = sb.pop_front();
                    chk("victim_found", victim_found, mx.found);
                    chk("victim_count", victim_count, mx.count);
                    if (mx.chk_entry) chk("victim_entry", victim_entry, mx.entry);
                    chk("rfm_latency", cyc - mx.acc, mx.lat);
                    chk("alert_at_done", rfm_alert, 0);
                end
            end
        end
    end

    task automatic preload(input logic [6:0] a, input logic [15:0] v);
        @(posedge clk); #1;
        pre_en = 1'b1; pre_addr = a; pre_val = v;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    task automatic do_act(input logic [6:0] e);
        int t; int acc;
        @(posedge clk); #1;
        act_valid = 1'b1; act_entry = e;
        t = 0; @(negedge clk);
        while (!act_ready && t < 50) begin @(negedge clk); t++; end
        chk("act_accept", act_ready, 1);
        acc = cyc;
        @(posedge clk); #1;
        act_valid = 1'b0; act_entry = e ^ 7'h55;
        t = 0; @(negedge clk);
        while (!act_ready && t < 50) begin @(negedge clk); t++; end
        chk("act_ready_back", cyc - acc, 3);
    endtask

    task automatic do_rfm(input logic f, input logic [6:0] e, input logic [15:0] c, input int lat);
        exp_t x; int t;
        @(posedge clk); #1;
        rfm_valid = 1'b1;
        t = 0; @(negedge clk);
        while (!rfm_ready && t < 50) begin @(negedge clk); t++; end
        chk("rfm_accept", rfm_ready, 1);
        x.found = f; x.entry = e; x.count = c; x.lat = lat; x.acc = cyc; x.chk_entry = f;
        sb.push_back(x);
        @(posedge clk); #1;
        rfm_valid = 1'b0;
        t = 0;
        while (sb.size() != 0 && t < 50) begin @(negedge clk); t++; end
        chk("rfm_done_seen", sb.size(), 0);
        sb.delete();
    endtask

    task automatic do_clr();
        int t;
        @(posedge clk); #1;
        clr_req = 1'b1;
        t = 0; @(negedge clk);
        while (!cam_reset && t < 50) begin @(negedge clk); t++; end
        chk("clr_cam_reset", cam_reset, 1);
        chk("clr_alert", rfm_alert, 0);
        @(posedge clk); #1;
        clr_req = 1'b0;
    endtask

    task automatic wait_init();
        int t; int nz;
        t = 0; @(negedge clk);
        while (!cam_reset && t < 20) begin @(negedge clk); t++; end
        chk("init_cam_reset", cam_reset, 1);
        @(negedge clk);
        chk("init_reset_1cyc", cam_reset, 0);
        t = 0;
        while (!act_ready && t < 20) begin @(negedge clk); t++; end
        chk("init_act_ready", act_ready, 1);
        nz = 0;
        for (int i = 0; i < 128; i++) if (mem[i] != 16'h0) nz++;
        chk("init_table_zero", nz, 0);
    endtask

    initial begin
        int w0; int d0; int clr_c; int rfm_c; int act_c; int nz;
        exp_t x;
        rstn = 1'b0; act_valid = 1'b0; act_entry = 7'd0; rfm_valid = 1'b0; clr_req = 1'b0;
        pre_en = 1'b0; pre_addr = 7'd0; pre_val = 16'h0;

        repeat (2) @(negedge clk);
        chk("rst_ctrl", {act_ready, rfm_ready, rfm_done, rfm_alert, victim_found}, 0);
        chk("rst_cam_en", {cam_read_en, cam_write_en, cam_search_en, cam_reset, cam_max_en}, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        wait_init();

        do_act(7'd5); do_act(7'd5); do_act(7'd5); do_act(7'd9);
        chk("cnt_entry5", mem[5], 3);
        chk("cnt_entry9", mem[9], 1);
        w0 = wr_cnt;
        do_rfm(1'b1, 7'd5, 16'd3, 8);
        chk("victim_writes", wr_cnt - w0, 1);
`ifdef RFM_CNT_HALVE_EN
        chk("entry5_after", mem[5], 1);
`else
        chk("entry5_after", mem[5], 0);
`endif
        chk("entry9_kept", mem[9], 1);

        do_clr();
        nz = 0;
        for (int i = 0; i < 128; i++) if (mem[i] != 16'h0) nz++;
        chk("clr_table_zero", nz, 0);
        w0 = wr_cnt;
        do_rfm(1'b0, 7'd0, 16'd0, 7);
        chk("empty_no_write", wr_cnt - w0, 0);

        preload(7'd3, 16'd1022);
        do_act(7'd3);
        chk("alert_below_th", rfm_alert, 0);
        do_act(7'd3);
        chk("alert_at_th", rfm_alert, 1);
        chk("cnt_entry3", mem[3], 1024);
        do_clr();

        preload(7'd2, 16'hFFFF);
        do_act(7'd2);
        chk("sat_value", mem[2], 16'hFFFF);
        chk("sat_alert", rfm_alert, 1);
        do_rfm(1'b1, 7'd2, 16'hFFFF, 8);
        chk("alert_after_done", rfm_alert, 0);
`ifdef RFM_CNT_HALVE_EN
        chk("entry2_after", mem[2], 16'h7FFF);
`else
        chk("entry2_after", mem[2], 0);
`endif

        // All three requests raised together in IDLE.
        @(posedge clk); #1;
        clr_req = 1'b1; rfm_valid = 1'b1; act_valid = 1'b1; act_entry = 7'd7;
        clr_c = -1; rfm_c = -1; act_c = -1;
        for (int k = 0; k < 60 && act_c < 0; k++) begin
            @(negedge clk);
            if (cam_reset && clr_c < 0) clr_c = cyc;
            if (rfm_valid && rfm_ready && rfm_c < 0) begin
                rfm_c = cyc;
                x.found = 1'b0; x.entry = 7'd0; x.count = 16'd0; x.lat = 7; x.acc = cyc; x.chk_entry = 1'b0;
                sb.push_back(x);
            end
            if (act_valid && act_ready && act_c < 0) act_c = cyc;
            @(posedge clk); #1;
            if (clr_c >= 0) clr_req = 1'b0;
            if (rfm_c >= 0) rfm_valid = 1'b0;
            if (act_c >= 0) begin act_valid = 1'b0; act_entry = 7'd0; end
        end
        chk("prio_clr_seen", clr_c >= 0, 1);
        chk("prio_rfm_after_clr", rfm_c - clr_c, 1);
        chk("prio_act_after_rfm", act_c - rfm_c, 8);
        chk("prio_rfm_done_first", sb.size(), 0);
        repeat (4) @(negedge clk);
        chk("prio_act_written", mem[7], 1);
        sb.delete();

        preload(7'd10, 16'd2000);
        do_act(7'd10);
        chk("pre_rst_alert", rfm_alert, 1);
        @(posedge clk); #1;
        rfm_valid = 1'b1;
        @(negedge clk);
        chk("mid_rfm_accept", rfm_ready, 1);
        @(posedge clk); #1;
        rfm_valid = 1'b0;
        @(negedge clk);
        chk("mid_in_max", cam_max_en, 1);
        d0 = done_cnt;
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_ctrl", {act_ready, rfm_ready, rfm_done, rfm_alert, victim_found}, 0);
        chk("mid_rst_cam_en", {cam_read_en, cam_write_en, cam_search_en, cam_reset, cam_max_en}, 0);
        chk("mid_rst_bus", {cam_addr_in, cam_data_in}, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        wait_init();
        repeat (10) @(negedge clk);
        chk("mid_rst_no_done", done_cnt - d0, 0);

        do_act(7'd4); do_act(7'd4);
        do_rfm(1'b1, 7'd4, 16'd2, 8);

        chk("bus_zero_when_idle", bus_viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
